conv_window_fetch: RTL and testbench
====================================

# conv_window_fetch

Window-fetch stage that sits directly downstream of the image address/index generator in the CNN convolution datapath. It accepts one output-pixel position (row i, column j) per handshake and reads the 3x3 input neighbourhood from the synchronous image RAM, row-major. It presents the assembled 9-tap window, tagged with its position, to the MAC/convolution stage over a valid/ready handshake. Positions that cannot host a full 3x3 window are rejected and flagged.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 28: image columns
- IMG_H, 28: image rows
- IDX_W, 10: width of the i/j position indices
- ADDR_W, 10: image RAM address width; IMG_W*IMG_H must be ≤ 2^ADDR_W
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- pos_valid  in  1  a position is offered
- pos_ready  out  1  block can accept a position
- pos_i  in  IDX_W  window top-left row
- pos_j  in  IDX_W  window top-left column
- mem_en  out  1  image RAM read enable
- mem_addr  out  ADDR_W  image RAM read address
- mem_rdata  in  DATA_W  RAM data, valid exactly one cycle after its mem_en/mem_addr
- win_valid  out  1  window is available
- win_ready  in  1  consumer accepts the window
- win_data  out  9*DATA_W  tap k = r*3+c at bits [k*DATA_W +: DATA_W]
- win_i, win_j  out  IDX_W  position of the presented window
- err_range  out  1  one-cycle pulse on a rejected position

## Operation
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE: pos_ready=1. When pos_valid is high at a rising edge, the block latches pos_i/pos_j.
  - If pos_i > IMG_H-3 or pos_j > IMG_W-3: the position is dropped, err_range=1 for the next cycle, and the FSM stays in IDLE.
  - Otherwise the FSM goes to FETCH with tap counter k=0.
- FETCH: pos_ready=0 and mem_en=1.
  - mem_addr = (i+r)*IMG_W + (j+c), with r=k/3 and c=k%3, k=0..8.
  - Row base is kept as a running register: it adds IMG_W on each row wrap. No multiplier is used.
  - All arithmetic is unsigned and truncated to ADDR_W bits.
  - After k=8 is issued, the FSM goes to DRAIN.
- Data capture: mem_rdata is written into tap slot k-1 on the cycle after address k-1 was issued. This applies in both FETCH and DRAIN.
- DRAIN: mem_en=0. The block captures tap 8, then goes to HOLD.
- HOLD: win_valid=1. win_data, win_i and win_j are stable until win_valid && win_ready at a rising edge. After that handshake the FSM returns to IDLE.
- win_data, win_i and win_j keep their last values after the handshake. win_i and win_j update when a position is accepted.
- win_valid never depends combinationally on win_ready.
- pos_ready is 0 in FETCH, DRAIN and HOLD, including the HOLD cycle where the handshake occurs. A new position is accepted no earlier than the cycle after the window handshake.

## Timing
- Reset values (immediate, asynchronous):
  - FSM=IDLE, pos_ready=1.
  - mem_en=0, mem_addr=0.
  - win_valid=0, win_data=0, win_i=0, win_j=0.
  - err_range=0, k=0.
- Cycle numbering: the position handshake is edge E0, and cycle n follows edge En.
  - Cycles 0–8: mem_en=1 with addresses for taps 0–8.
  - Cycles 1–9: data for taps 0–8 is captured.
  - Cycle 9: DRAIN.
  - Cycle 10: first cycle with win_valid=1.
- Minimum throughput is one window per 12 cycles (win_ready held high).
- Reset mid-operation: all state clears, and any in-flight RAM return is ignored. The first position offered after rst deasserts is processed from k=0.
- Rejected positions issue no mem_en. A new position can be accepted on the cycle after the rejection.
- Boundary positions: i=IMG_H-3 and j=IMG_W-3 (25,25 by default) are valid, and the last address is IMG_W*IMG_H-1.

## Test plan
- Reset: assert rst with the block idle. Required: pos_ready=1, mem_en=0, win_valid=0, win_data=0, err_range=0. Then assert rst mid-FETCH. Required: all outputs return to their reset values in the same cycle.
- Origin: use RAM contents mem[a]=a mod 256 and offer (0,0). Required addresses: 0,1,2,28,29,30,56,57,58 in cycles 0–8. win_valid rises in cycle 10 with taps 0..8 = 0,1,2,28,29,30,56,57,58 and win_i=win_j=0.
- Corner: offer (25,25). Required addresses: 725–727, 753–755, 781–783. Tap values are those addresses mod 256: 213,214,215,241,242,243,13,14,15.
- Out-of-range: offer (26,0), then (0,26). Required: a one-cycle err_range pulse for each, no mem_en, and pos_ready staying 1.
- Backpressure: hold win_ready=0 for 5 cycles after win_valid rises. Required: win_data, win_i and win_j stay stable, pos_ready=0 and mem_en=0. After win_ready rises, win_valid=0 and pos_ready=1 on the next cycle.
- Stream: drive all 676 positions in raster order from an upstream model with win_ready held at 1. Required: each window matches a reference 3x3 extraction, with no drops or duplicates.

Source files
------------

// File: rtl/conv_window_fetch.sv
// 3x3 window fetch: takes a top-left position, reads the nine neighbourhood pixels
// row-major from a synchronous RAM and presents them as one tagged window.
module conv_window_fetch #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int IDX_W  = 10,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pos_valid,
    output logic                  pos_ready,
    input  logic [IDX_W-1:0]      pos_i,
    input  logic [IDX_W-1:0]      pos_j,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [IDX_W-1:0]      win_i,
    output logic [IDX_W-1:0]      win_j,
    output logic                  err_range
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    localparam logic [IDX_W-1:0]  I_MAX      = IDX_W'(IMG_H - 3);
    localparam logic [IDX_W-1:0]  J_MAX      = IDX_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
    localparam logic [31:0]       IMG_W_BITS = 32'(IMG_W);

    state_t              state, state_nxt;
    logic [3:0]          k;
    logic [1:0]          col;
    logic [ADDR_W-1:0]   row_base;
    logic                vld_p1;
    logic [3:0]          tap_p1;
    logic                in_range;
    logic                accept;

    // Starting row base i*IMG_W built as a sum of shifted copies of i.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [IDX_W-1:0] i);
        logic [ADDR_W+IDX_W-1:0] ie;
        logic [ADDR_W-1:0]       acc;
        ie  = (ADDR_W+IDX_W)'(i);
        acc = '0;
        for (int b = 0; b < 32; b++) begin
            if (IMG_W_BITS[b]) begin
                acc = acc + ADDR_W'(ie << b);
            end
        end
        return acc;
    endfunction

    assign in_range = (pos_i <= I_MAX) && (pos_j <= J_MAX);
    assign accept   = (state == IDLE) && pos_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_ready = 1'b0;
        mem_en    = 1'b0;
        win_valid = 1'b0;
        case (state)
            IDLE: begin
                pos_ready = 1'b1;
                if (pos_valid && in_range) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_en = 1'b1;
                if (k == 4'd8) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        mem_addr = mem_en ? (row_base + ADDR_W'(win_j) + ADDR_W'(col)) : '0;
    end

    // Stage p0: address walk; stage p1: RAM return lands in its tap slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            col       <= '0;
            row_base  <= '0;
            win_i     <= '0;
            win_j     <= '0;
            err_range <= 1'b0;
            vld_p1    <= 1'b0;
            tap_p1    <= '0;
            win_data  <= '0;
        end else begin
            err_range <= accept && !in_range;
            vld_p1    <= mem_en;
            tap_p1    <= k;
            if (accept && in_range) begin
                win_i    <= pos_i;
                win_j    <= pos_j;
                row_base <= row_offset(pos_i);
                k        <= '0;
                col      <= '0;
            end else if (mem_en) begin
                k <= k + 4'd1;
                if (col == 2'd2) begin
                    col      <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    col <= col + 2'd1;
                end
            end
            for (int t = 0; t < 9; t++) begin
                if (vld_p1 && (tap_p1 == 4'(t))) begin
                    win_data[t*DATA_W +: DATA_W] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: RAM model, per-cycle reference model and directed cases.
module tb_conv_window_fetch;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int IDX_W  = 10;
    localparam int ADDR_W = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                pos_valid;
    logic                pos_ready;
    logic [IDX_W-1:0]    pos_i, pos_j;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                win_valid;
    logic                win_ready;
    logic [9*DATA_W-1:0] win_data;
    logic [IDX_W-1:0]    win_i, win_j;
    logic                err_range;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;

    conv_window_fetch #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_i(pos_i), .pos_j(pos_j),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_i(win_i), .win_j(win_j), .err_range(err_range)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_val(input int a);
        if (mode == 0) return 8'(a);
        return 8'((a * 37) ^ (a >> 3));
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram_val(int'(mem_addr));
    end

    function automatic logic [9*DATA_W-1:0] window(input int i, input int j);
        logic [9*DATA_W-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DATA_W +: DATA_W] = ram_val((i + r) * IMG_W + j + c);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: job position n counts cycles after the position handshake.
    bit                  m_busy = 0;
    bit                  m_err  = 0;
    int                  m_n = 0, m_i = 0, m_j = 0, m_done = 0;
    logic [9*DATA_W-1:0] m_taps = '0;

    always @(posedge clk) begin
        m_err = 0;
        if (rst) begin
            m_busy = 0;
            m_n    = 0;
        end else if (m_busy) begin
            if (m_n >= 10 && win_ready) begin
                m_busy = 0;
                m_done++;
            end else begin
                m_n++;
            end
        end else if (pos_valid) begin
            if (int'(pos_i) <= IMG_H - 3 && int'(pos_j) <= IMG_W - 3) begin
                m_busy = 1;
                m_n    = 0;
                m_i    = int'(pos_i);
                m_j    = int'(pos_j);
                m_taps = window(m_i, m_j);
            end else begin
                m_err = 1;
            end
        end
        #2;
        if (rst) begin
            chk("rst_pos_ready", pos_ready, 1);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_win_valid", win_valid, 0);
            chk("rst_win_data", win_data, 0);
            chk("rst_win_ij", {win_i, win_j}, 0);
            chk("rst_err", err_range, 0);
        end else begin
            chk("m_pos_ready", pos_ready, !m_busy);
            chk("m_mem_en", mem_en, m_busy && m_n <= 8);
            if (m_busy && m_n <= 8)
                chk("m_mem_addr", mem_addr, (m_i + m_n / 3) * IMG_W + m_j + m_n % 3);
            chk("m_win_valid", win_valid, m_busy && m_n >= 10);
            if (m_busy && m_n >= 10) begin
                chk("m_win_data", win_data, m_taps);
                chk("m_win_i", win_i, m_i);
                chk("m_win_j", win_j, m_j);
            end
            chk("m_err_range", err_range, m_err);
        end
    end

    // Called at a falling edge; returns at the falling edge of cycle 0.
    task automatic offer(input int i, input int j);
        bit ok;
        ok        = 0;
        pos_i     = IDX_W'(i);
        pos_j     = IDX_W'(j);
        pos_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (pos_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        pos_valid = 1'b0;
        if (!ok) chk("offer_timeout", 0, 1);
    endtask

    task automatic directed(input int i, input int j, input int addrs[9], input int taps[9]);
        logic [9*DATA_W-1:0] w;
        w = '0;
        for (int t = 0; t < 9; t++) w[t*DATA_W +: DATA_W] = 8'(taps[t]);
        offer(i, j);
        for (int n = 0; n < 9; n++) begin
            chk("dir_mem_en", mem_en, 1);
            chk("dir_addr", mem_addr, addrs[n]);
            @(negedge clk);
        end
        chk("dir_drain_en", mem_en, 0);
        chk("dir_drain_valid", win_valid, 0);
        @(negedge clk);
        chk("dir_valid", win_valid, 1);
        chk("dir_data", win_data, w);
        chk("dir_ij", {win_i, win_j}, {IDX_W'(i), IDX_W'(j)});
        @(negedge clk);
        chk("dir_done_valid", win_valid, 0);
        chk("dir_done_ready", pos_ready, 1);
    endtask

    initial begin
        int a0[9], t0[9], a1[9], t1[9];
        int done0;
        bit seen;
        a0 = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        t0 = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        a1 = '{725, 726, 727, 753, 754, 755, 781, 782, 783};
        t1 = '{213, 214, 215, 241, 242, 243, 13, 14, 15};

        rst = 1'b1; pos_valid = 1'b0; pos_i = '0; pos_j = '0; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_idle", {pos_ready, mem_en, win_valid, err_range}, 4'b1000);
        chk("reset_data", win_data, 0);
        rst = 1'b0;
        @(negedge clk);

        directed(0, 0, a0, t0);
        directed(25, 25, a1, t1);

        // Reset in the middle of a fetch
        offer(3, 4);
        @(negedge clk); @(negedge clk);
        chk("pre_rst_mem_en", mem_en, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {pos_ready, mem_en, win_valid, err_range}, 4'b1000);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_data", win_data, 0);
        chk("mid_rst_ij", {win_i, win_j}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        directed(0, 0, a0, t0);

        // Out-of-range positions
        offer(26, 0);
        chk("oor1_err", err_range, 1);
        chk("oor1_en", mem_en, 0);
        chk("oor1_ready", pos_ready, 1);
        @(negedge clk);
        chk("oor1_pulse", err_range, 0);
        offer(0, 26);
        chk("oor2_err", err_range, 1);
        chk("oor2_en", mem_en, 0);
        chk("oor2_ready", pos_ready, 1);
        @(negedge clk);
        chk("oor2_pulse", err_range, 0);
        chk("oor2_en2", mem_en, 0);

        // Backpressure
        win_ready = 1'b0;
        offer(1, 2);
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            if (win_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("bp_valid_seen", seen, 1);
        for (int t = 0; t < 5; t++) begin
            chk("bp_ready", pos_ready, 0);
            chk("bp_en", mem_en, 0);
            chk("bp_ij", {win_i, win_j}, {IDX_W'(1), IDX_W'(2)});
            @(negedge clk);
        end
        win_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", win_valid, 0);
        chk("bp_release_ready", pos_ready, 1);

        // Raster stream with different RAM contents
        mode  = 1;
        done0 = m_done;
        for (int i = 0; i <= IMG_H - 3; i++)
            for (int j = 0; j <= IMG_W - 3; j++)
                offer(i, j);
        seen = 0;
        for (int t = 0; t < 30; t++) begin
            if (pos_ready && !m_busy) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("stream_idle", seen, 1);
        chk("stream_count", m_done - done0, (IMG_H - 2) * (IMG_W - 2));

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
